// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
// Groups the parallel word handshake and the serial output of piso_serializer.
//   DIN        parallel word, MSB transmitted first
//   DVALID     DIN valid
//   DREADY     holding buffer can take a word
//   SOUT       serial data to the downstream shift register D
//   SCE        shift enable to the downstream shift register CE
//   LAST       high with SCE on the final bit of a word
//   BUSY       transmitter active or holding a word
//   FRAME_DONE one-cycle pulse after a word's final bit
// master: the word producer / serial consumer side. slave: the serializer.
// -----------------------------------------------------------------------------
interface piso_serializer_if #(
   parameter int unsigned N = 8
) ();

   logic [N-1:0] DIN;
   logic         DVALID;
   logic         DREADY;
   logic         SOUT;
   logic         SCE;
   logic         LAST;
   logic         BUSY;
   logic         FRAME_DONE;

   modport master (
      output DIN,
      output DVALID,
      input  DREADY,
      input  SOUT,
      input  SCE,
      input  LAST,
      input  BUSY,
      input  FRAME_DONE
   );

   modport slave (
      input  DIN,
      input  DVALID,
      output DREADY,
      output SOUT,
      output SCE,
      output LAST,
      output BUSY,
      output FRAME_DONE
   );

endinterface

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in, serial-out transmitter feeding an N-bit serial-in shift register.
// Words are accepted on a valid/ready handshake into a one-deep holding buffer,
// then shifted out MSB first, one bit per DIV clock cycles, with SCE high in
// the last cycle of each bit period. GAP idle bit periods separate words.
//
// Parameters:
//   N    word width (N >= 2)
//   DIV  clock cycles per bit period (DIV >= 1)
//   GAP  idle bit periods between consecutive words (GAP >= 0)
// Ports:
//   CLK     rising-edge clock
//   RST     synchronous active-high reset; discards current and held words
//   io_bus  slave side of piso_serializer_if (handshake + serial outputs)
// -----------------------------------------------------------------------------
module piso_serializer #(
   parameter int unsigned N   = 8,
   parameter int unsigned DIV = 1,
   parameter int unsigned GAP = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   piso_serializer_if.slave      io_bus
);

   localparam int unsigned BitW   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DivW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned GapCyc = GAP * DIV;
   localparam int unsigned GapW   = (GapCyc > 1) ? $clog2(GapCyc) : 1;

   localparam logic [BitW-1:0] BitLast = BitW'(N - 1);
   localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
   localparam logic [GapW-1:0] GapLast = GapW'((GapCyc > 0) ? GapCyc - 1 : 0);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap
   } state_t;

   // State
   state_t          r_state;
   logic [N-1:0]    r_shifter;
   logic [N-1:0]    r_hold;
   logic            r_hold_full;
   logic [BitW-1:0] r_bit_cnt;
   logic [DivW-1:0] r_div_cnt;
   logic [GapW-1:0] r_gap_cnt;
   logic            r_frame_done;

   // Next-state and decoded outputs
   state_t          w_state_nxt;
   logic [N-1:0]    w_shifter_nxt;
   logic [N-1:0]    w_hold_nxt;
   logic            w_hold_full_nxt;
   logic [BitW-1:0] w_bit_nxt;
   logic [DivW-1:0] w_div_nxt;
   logic [GapW-1:0] w_gap_nxt;
   logic            w_load;
   logic            w_accept;
   logic            w_dready;
   logic            w_sout;
   logic            w_sce;
   logic            w_last;

   // Ready depends on the buffer flag only; RST gating keeps DREADY low
   // during reset without involving DVALID.
   assign w_dready = !r_hold_full && !RST;
   assign w_accept = io_bus.DVALID && w_dready;

   always_comb begin
      w_state_nxt   = r_state;
      w_shifter_nxt = r_shifter;
      w_bit_nxt     = r_bit_cnt;
      w_div_nxt     = r_div_cnt;
      w_gap_nxt     = r_gap_cnt;
      w_load        = 1'b0;
      w_sout        = 1'b0;
      w_sce         = 1'b0;
      w_last        = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (r_hold_full) begin
               w_load = 1'b1;
            end
         end

         StShift: begin
            w_sout = r_shifter[N-1];
            w_sce  = (r_div_cnt == DivLast);
            w_last = w_sce && (r_bit_cnt == BitLast);
            if (w_sce) begin
               w_div_nxt     = '0;
               w_shifter_nxt = {r_shifter[N-2:0], 1'b0};
               if (w_last) begin
                  w_bit_nxt = '0;
                  if (GapCyc > 0) begin
                     w_state_nxt = StGap;
                     w_gap_nxt   = '0;
                  end else if (r_hold_full) begin
                     // Back-to-back: next word's MSB follows with no bubble.
                     w_load = 1'b1;
                  end else begin
                     w_state_nxt = StIdle;
                  end
               end else begin
                  w_bit_nxt = r_bit_cnt + 1'b1;
               end
            end else begin
               w_div_nxt = r_div_cnt + 1'b1;
            end
         end

         StGap: begin
            if (r_gap_cnt == GapLast) begin
               w_gap_nxt = '0;
               if (r_hold_full) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = StIdle;
               end
            end else begin
               w_gap_nxt = r_gap_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nxt = StIdle;
         end
      endcase

      // Loading the shifter drains the holding buffer and restarts both counters.
      if (w_load) begin
         w_state_nxt   = StShift;
         w_shifter_nxt = r_hold;
         w_bit_nxt     = '0;
         w_div_nxt     = '0;
      end
   end

   // Drain and accept never coincide: drain needs a full buffer, accept an empty one.
   always_comb begin
      w_hold_full_nxt = r_hold_full;
      w_hold_nxt      = r_hold;
      if (w_load) begin
         w_hold_full_nxt = 1'b0;
      end
      if (w_accept) begin
         w_hold_full_nxt = 1'b1;
         w_hold_nxt      = io_bus.DIN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= StIdle;
         r_shifter    <= '0;
         r_hold       <= '0;
         r_hold_full  <= 1'b0;
         r_bit_cnt    <= '0;
         r_div_cnt    <= '0;
         r_gap_cnt    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shifter    <= w_shifter_nxt;
         r_hold       <= w_hold_nxt;
         r_hold_full  <= w_hold_full_nxt;
         r_bit_cnt    <= w_bit_nxt;
         r_div_cnt    <= w_div_nxt;
         r_gap_cnt    <= w_gap_nxt;
         r_frame_done <= w_last;
      end
   end

   assign io_bus.DREADY     = w_dready;
   assign io_bus.SOUT       = w_sout;
   assign io_bus.SCE        = w_sce;
   assign io_bus.LAST       = w_last;
   assign io_bus.BUSY       = (r_state != StIdle) || r_hold_full;
   assign io_bus.FRAME_DONE = r_frame_done;

endmodule
